// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - state encoding, wait-counter width and clog2 helper shared by the SRAM arbiter
package sram_arb_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   // Wide enough for WAIT_CYC up to 15
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      S_IDLE   = ST_IDLE,
      S_ACCESS = ST_ACCESS,
      S_DONE   = ST_DONE
   } state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/sram_arb_picker.sv
// rtl/sram_arb_picker.sv - combinational winner select; SRAM_ARB_ROUND_ROBIN_EN selects round-robin, else fixed priority
module sram_arb_picker
   import sram_arb_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int IDX_W  = clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [IDX_W-1:0]  last_grant,
   output logic              grant_valid,
   output logic [IDX_W-1:0]  grant_idx
);

`ifdef SRAM_ARB_ROUND_ROBIN_EN

   logic [IDX_W-1:0] cand;

   // Search from last_grant+1 upward with wrap; walking offsets downward lets the nearest requester win
   always_comb begin
      grant_valid = |req;
      grant_idx   = '0;
      cand        = '0;
      for (int off = NUM_CH; off >= 1; off--) begin
         cand = IDX_W'((int'(last_grant) + off) % NUM_CH);
         if (req[cand]) grant_idx = cand;
      end
   end

`else

   // The rotation pointer only matters for round-robin
   logic unused_last_grant;
   assign unused_last_grant = ^last_grant;

   // Fixed priority: lowest requesting index wins, as in the legacy mux
   always_comb begin
      grant_valid = |req;
      grant_idx   = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (req[i]) grant_idx = IDX_W'(i);
      end
   end

`endif

endmodule

// File: rtl/sram_arbiter_mp.sv
// rtl/sram_arbiter_mp.sv - N-channel req/ack arbiter and access FSM for the external async SRAM (SRAM_ARB_ROUND_ROBIN_EN: round-robin)
module sram_arbiter_mp
   import sram_arb_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int ADDR_W   = 21,
   parameter int DATA_W   = 8,
   parameter int WAIT_CYC = 1,
   localparam int IDX_W   = clog2(NUM_CH)
) (
   input  logic                     clka,
   input  logic                     reset_n,
   input  logic [NUM_CH-1:0]        req,
   input  logic [NUM_CH-1:0]        we,
   input  logic [NUM_CH*ADDR_W-1:0] addr,
   input  logic [NUM_CH*DATA_W-1:0] wdata,
   output logic [NUM_CH-1:0]        ack,
   output logic [DATA_W-1:0]        rdata,
   output logic                     busy,
   output logic [IDX_W-1:0]         grant_id,
   output logic [ADDR_W-1:0]        SRAM_ADDR,
   input  logic [DATA_W-1:0]        SRAM_DATA_i,
   output logic [DATA_W-1:0]        SRAM_DATA_o,
   output logic                     SRAM_DATA_oe,
   output logic                     SRAM_WE_n,
   output logic                     SRAM_OE_n
);

   // Counter value of the final (hold) ACCESS cycle
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYC);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              wr_q, wr_d;
   logic [IDX_W-1:0]  grant_q, grant_d;
   logic [IDX_W-1:0]  last_q, last_d;
   logic [NUM_CH-1:0] ack_q, ack_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              doe_q, doe_d;
   logic              we_n_q, we_n_d;
   logic              oe_n_q, oe_n_d;

   logic              pick_valid;
   logic [IDX_W-1:0]  pick_idx;

   sram_arb_picker #(
      .NUM_CH (NUM_CH),
      .IDX_W  (IDX_W)
   ) u_picker (
      .req         (req),
      .last_grant  (last_q),
      .grant_valid (pick_valid),
      .grant_idx   (pick_idx)
   );

   // Next-state and next-pin values; every pin is computed one cycle ahead so it leaves a flop
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      grant_d = grant_q;
      last_d  = last_q;
      ack_d   = '0;
      rdata_d = rdata_q;
      dout_d  = dout_q;
      addr_d  = addr_q;
      doe_d   = doe_q;
      we_n_d  = we_n_q;
      oe_n_d  = oe_n_q;

      unique case (state_q)
         S_IDLE: begin
            if (pick_valid) begin
               state_d = S_ACCESS;
               cnt_d   = '0;
               wr_d    = we[pick_idx];
               grant_d = pick_idx;
               last_d  = pick_idx;
               addr_d  = addr[int'(pick_idx) * ADDR_W +: ADDR_W];
               dout_d  = wdata[int'(pick_idx) * DATA_W +: DATA_W];
               // Cycle 0 of ACCESS: write strobe low (WAIT_CYC >= 1), or output enable low for a read
               we_n_d  = ~we[pick_idx];
               oe_n_d  = we[pick_idx];
               doe_d   = we[pick_idx];
            end
         end

         S_ACCESS: begin
            if (cnt_q == LAST_CNT) begin
               state_d        = S_DONE;
               ack_d[grant_q] = 1'b1;
               we_n_d         = 1'b1;
               oe_n_d         = 1'b1;
               doe_d          = 1'b0;
               if (!wr_q) rdata_d = SRAM_DATA_i;
            end else begin
               cnt_d  = cnt_q + 1'b1;
               // WE_n rises for the final cycle so address and data are held past the strobe
               we_n_d = ~(wr_q && (cnt_d < LAST_CNT));
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and pin registers; async reset releases the strobes immediately and drops any transfer
   always_ff @(posedge clka or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         grant_q <= '0;
         last_q  <= IDX_W'(NUM_CH - 1);
         ack_q   <= '0;
         rdata_q <= '0;
         dout_q  <= '0;
         addr_q  <= '0;
         doe_q   <= 1'b0;
         we_n_q  <= 1'b1;
         oe_n_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         ack_q   <= ack_d;
         rdata_q <= rdata_d;
         dout_q  <= dout_d;
         addr_q  <= addr_d;
         doe_q   <= doe_d;
         we_n_q  <= we_n_d;
         oe_n_q  <= oe_n_d;
      end
   end

   assign ack          = ack_q;
   assign rdata        = rdata_q;
   assign busy         = (state_q != S_IDLE);
   assign grant_id     = grant_q;
   assign SRAM_ADDR    = addr_q;
   assign SRAM_DATA_o  = dout_q;
   assign SRAM_DATA_oe = doe_q;
   assign SRAM_WE_n    = we_n_q;
   assign SRAM_OE_n    = oe_n_q;

endmodule

// File: tb/tb_sram_arbiter_mp.sv
// tb/tb_sram_arbiter_mp.sv - scoreboard bench for sram_arbiter_mp with SRAM model and arbitration reference model
`timescale 1ns/1ps
module tb_sram_arbiter_mp;

   localparam int NUM_CH   = 4;
   localparam int ADDR_W   = 21;
   localparam int DATA_W   = 8;
   localparam int WAIT_CYC = 1;
   localparam int IDX_W    = 2;

   logic                     clka = 1'b0;
   logic                     reset_n = 1'b0;
   logic [NUM_CH-1:0]        req = '0;
   logic [NUM_CH-1:0]        we = '0;
   logic [NUM_CH*ADDR_W-1:0] addr_bus = '0;
   logic [NUM_CH*DATA_W-1:0] wdata_bus = '0;
   logic [NUM_CH-1:0]        ack;
   logic [DATA_W-1:0]        rdata;
   logic                     busy;
   logic [IDX_W-1:0]         grant_id;
   logic [ADDR_W-1:0]        SRAM_ADDR;
   logic [DATA_W-1:0]        sram_di = 8'hEE;
   logic [DATA_W-1:0]        SRAM_DATA_o;
   logic                     SRAM_DATA_oe, SRAM_WE_n, SRAM_OE_n;

   always #5 clka = ~clka;

   sram_arbiter_mp #(
      .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYC(WAIT_CYC)
   ) dut (
      .clka(clka), .reset_n(reset_n), .req(req), .we(we), .addr(addr_bus), .wdata(wdata_bus),
      .ack(ack), .rdata(rdata), .busy(busy), .grant_id(grant_id),
      .SRAM_ADDR(SRAM_ADDR), .SRAM_DATA_i(sram_di), .SRAM_DATA_o(SRAM_DATA_o),
      .SRAM_DATA_oe(SRAM_DATA_oe), .SRAM_WE_n(SRAM_WE_n), .SRAM_OE_n(SRAM_OE_n)
   );

   typedef struct {
      int                ch;
      bit                wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [DATA_W-1:0] rdata;
      int                cyc;
   } exp_t;

   exp_t              exp_q[$];
   logic [DATA_W-1:0] sram_mem [logic [ADDR_W-1:0]];
   logic [DATA_W-1:0] ref_mem  [logic [ADDR_W-1:0]];
   int                n_checks = 0;
   int                n_errors = 0;
   int                cyc = 0;
   int                m_last = NUM_CH - 1;
   logic [DATA_W-1:0] m_rdata = '0;
   bit                expect_drop = 1'b0;

   bit   [NUM_CH-1:0] r_we;
   logic [ADDR_W-1:0] r_addr  [NUM_CH];
   logic [DATA_W-1:0] r_wdata [NUM_CH];
   int                r_reps  [NUM_CH];

   always @(posedge clka) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Contents of never-written SRAM locations
   function automatic logic [DATA_W-1:0] fill(input logic [ADDR_W-1:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h3C;
   endfunction

   // Arbitration rule: which pending channel is served next
   function automatic int pick(input int rem[NUM_CH], input int last);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      for (int off = 1; off <= NUM_CH; off++)
         if (rem[(last + off) % NUM_CH] > 0) return (last + off) % NUM_CH;
`else
      for (int c = 0; c < NUM_CH; c++)
         if (rem[c] > 0) return c;
`endif
      return -1;
   endfunction

   task automatic set_ch(input int c, input bit w, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input int n);
      r_we[c] = w; r_addr[c] = a; r_wdata[c] = d; r_reps[c] = n;
   endtask

   // Predict the service order, timing and data of one burst of requests
   task automatic model_round(input bit [NUM_CH-1:0] mask, input int late, input int start);
      int   rem[NUM_CH];
      int   c, t;
      bit   first;
      exp_t e;
      for (int i = 0; i < NUM_CH; i++) rem[i] = mask[i] ? r_reps[i] : 0;
      t = start + WAIT_CYC + 2;
      first = 1'b1;
      forever begin
         c = pick(rem, m_last);
         if (c < 0) break;
         e.ch = c; e.wr = r_we[c]; e.addr = r_addr[c]; e.wdata = r_wdata[c];
         if (e.wr) ref_mem[e.addr] = e.wdata;
         else m_rdata = ref_mem.exists(e.addr) ? ref_mem[e.addr] : fill(e.addr);
         e.rdata = m_rdata;
         e.cyc = t;
         exp_q.push_back(e);
         rem[c]--;
         m_last = c;
         t += WAIT_CYC + 3;
         if (first && late >= 0) rem[late] = r_reps[late];
         first = 1'b0;
      end
   endtask

   // Raise mask now and 'late' one cycle later; hold each req until its repeat count is acked
   task automatic run_round(input bit [NUM_CH-1:0] mask, input int late);
      int rem[NUM_CH];
      int total, guard;
      bit raised;
      @(negedge clka);
      total = 0;
      for (int c = 0; c < NUM_CH; c++) begin
         we[c] = r_we[c];
         addr_bus[c*ADDR_W +: ADDR_W]  = r_addr[c];
         wdata_bus[c*DATA_W +: DATA_W] = r_wdata[c];
         rem[c] = (mask[c] || c == late) ? r_reps[c] : 0;
         total += rem[c];
      end
      req = mask;
      model_round(mask, late, cyc);
      raised = 1'b0;
      guard = 0;
      while (total > 0 && guard < 400) begin
         @(negedge clka);
         guard++;
         if (!raised && late >= 0) begin req[late] = 1'b1; raised = 1'b1; end
         for (int c = 0; c < NUM_CH; c++) begin
            if (ack[c] && rem[c] > 0) begin
               rem[c]--;
               total--;
               if (rem[c] == 0) req[c] = 1'b0;
            end
         end
      end
      if (total > 0) begin
         check("round_timeout", total, 0);
         req = '0;
      end
   endtask

   // SRAM model: writes land while WE_n is low; reads drive data while OE_n is low
   initial begin
      forever begin
         @(negedge clka);
         if (!SRAM_WE_n && SRAM_DATA_oe) sram_mem[SRAM_ADDR] = SRAM_DATA_o;
         if (!SRAM_OE_n) sram_di = sram_mem.exists(SRAM_ADDR) ? sram_mem[SRAM_ADDR] : fill(SRAM_ADDR);
         else sram_di = 8'hEE;
      end
   end

   // Monitor: pin legality every cycle, scoreboard pop on every ack
   initial begin
      int   n_we, n_oe, n_doe;
      bit   bad;
      exp_t e;
      n_we = 0; n_oe = 0; n_doe = 0;
      forever begin
         @(negedge clka);
         if (!reset_n) begin
            n_we = 0; n_oe = 0; n_doe = 0;
         end else begin
            bad = (!SRAM_WE_n && !SRAM_OE_n) || (SRAM_DATA_oe && !SRAM_OE_n) || (!SRAM_WE_n && !SRAM_DATA_oe);
            check("strobe_overlap", bad, 0);
            if (!SRAM_WE_n || !SRAM_OE_n || SRAM_DATA_oe) begin
               if (exp_q.size() > 0) begin
                  check("addr_during_strobe", SRAM_ADDR, exp_q[0].addr);
                  if (SRAM_DATA_oe) check("data_during_write", SRAM_DATA_o, exp_q[0].wdata);
               end else if (!expect_drop) begin
                  check("strobe_without_request", 1, 0);
               end
               n_we  += int'(!SRAM_WE_n);
               n_oe  += int'(!SRAM_OE_n);
               n_doe += int'(SRAM_DATA_oe);
            end
            if (|ack) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_ack", ack, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("ack_channel", ack, 32'(1) << e.ch);
                  check("grant_id", grant_id, e.ch);
                  check("ack_cycle", cyc, e.cyc);
                  check("rdata", rdata, e.rdata);
                  check("addr_held", SRAM_ADDR, e.addr);
                  check("we_low_cycles", n_we, e.wr ? WAIT_CYC : 0);
                  check("oe_low_cycles", n_oe, e.wr ? 0 : WAIT_CYC + 1);
                  check("data_oe_cycles", n_doe, e.wr ? WAIT_CYC + 1 : 0);
                  check("busy_in_done", busy, 1);
               end
               n_we = 0; n_oe = 0; n_doe = 0;
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit [NUM_CH-1:0]   mask;
      int                late;
      logic [ADDR_W-1:0] a;

      repeat (3) @(negedge clka);
      check("rst_ack", ack, 0);
      check("rst_rdata", rdata, 0);
      check("rst_grant_id", grant_id, 0);
      check("rst_addr", SRAM_ADDR, 0);
      check("rst_data_o", SRAM_DATA_o, 0);
      check("rst_data_oe", SRAM_DATA_oe, 0);
      check("rst_we_n", SRAM_WE_n, 1);
      check("rst_oe_n", SRAM_OE_n, 1);
      check("rst_busy", busy, 0);
      reset_n = 1'b1;

      // ch1 read returning 0x5A
      sram_mem[21'h01234] = 8'h5A;
      ref_mem[21'h01234]  = 8'h5A;
      set_ch(1, 1'b0, 21'h01234, 8'h00, 1);
      run_round(4'b0010, -1);

      // ch2 write, then read it back through ch0
      set_ch(2, 1'b1, 21'h1FFFF, 8'hA5, 1);
      run_round(4'b0100, -1);
      set_ch(0, 1'b0, 21'h1FFFF, 8'h00, 1);
      run_round(4'b0001, -1);

      // All four requesting with ch0 held for three accesses
      for (int c = 0; c < NUM_CH; c++)
         set_ch(c, (c % 2) == 1, ADDR_W'(32'h100 + c), DATA_W'(8'h10 + c), (c == 0) ? 3 : 1);
      run_round(4'b1111, -1);

      // ch3 read with ch0 arriving mid-access
      set_ch(3, 1'b0, 21'h00777, 8'h00, 1);
      set_ch(0, 1'b1, 21'h00777, 8'h3E, 1);
      run_round(4'b1000, 0);

      // Reset during write cycle 0
      @(negedge clka);
      we[2] = 1'b1;
      addr_bus[2*ADDR_W +: ADDR_W]  = 21'h1ABCD;
      wdata_bus[2*DATA_W +: DATA_W] = 8'hC3;
      expect_drop = 1'b1;
      req = 4'b0100;
      @(negedge clka);
      check("we_low_before_reset", SRAM_WE_n, 0);
      reset_n = 1'b0;
      req = '0;
      #1;
      check("reset_we_n", SRAM_WE_n, 1);
      check("reset_data_oe", SRAM_DATA_oe, 0);
      check("reset_oe_n", SRAM_OE_n, 1);
      check("reset_busy", busy, 0);
      check("reset_ack", ack, 0);
      @(negedge clka);
      @(negedge clka);
      reset_n = 1'b1;
      m_last  = NUM_CH - 1;
      m_rdata = '0;
      repeat (3) begin
         @(negedge clka);
         check("idle_after_reset", busy, 0);
      end
      expect_drop = 1'b0;

      // Randomized bursts
      for (int r = 0; r < 60; r++) begin
         mask = NUM_CH'($urandom_range(1, 15));
         late = -1;
         if (mask != 4'hF && $urandom_range(0, 1) == 1) begin
            do late = $urandom_range(0, NUM_CH - 1); while (mask[late]);
         end
         for (int c = 0; c < NUM_CH; c++) begin
            a = ADDR_W'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) a = a | 21'h1FFF0;
            set_ch(c, $urandom_range(0, 1) == 1, a, DATA_W'($urandom), $urandom_range(1, 2));
         end
         run_round(mask, late);
         repeat ($urandom_range(0, 2)) @(negedge clka);
      end

      repeat (5) @(negedge clka);
      check("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
